// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encoding and class enum
// for the Mini SRC hardwired control sequencer.
package ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_INC = 5'b11111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU3,
    C_IMM,
    C_MULDIV,
    C_UNARY,
    C_NOP,
    C_HALT,
    C_ILLEGAL
  } cls_e;

endpackage

// File: rtl/control_sequencer_op_classify.sv
// Opcode to instruction-class decoder; the only
// place opcodes are interpreted.
module op_classify
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output cls_e       cls_o
);

  always_comb begin
    cls_o = C_ILLEGAL;
    unique case (1'b1)
      (opcode_i >= OP_ADD && opcode_i <= OP_SHL):
        cls_o = C_ALU3;
      (opcode_i >= OP_ADDI && opcode_i <= OP_ORI):
        cls_o = C_IMM;
      (opcode_i == OP_DIV || opcode_i == OP_MUL):
        cls_o = C_MULDIV;
      (opcode_i == OP_NEG || opcode_i == OP_NOT):
        cls_o = C_UNARY;
      (opcode_i == OP_NOP):
        cls_o = C_NOP;
      (opcode_i == OP_HALT):
        cls_o = C_HALT;
      default:
        cls_o = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC hardwired control unit: fetch/decode/
// execute FSM, strobe decode and retire counter.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int COUNT_W         = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [31:0]        ir,
  output logic               pout,
  output logic               maren,
  output logic               zloen,
  output logic               zhien,
  output logic               zloout,
  output logic               zhiout,
  output logic               pen,
  output logic               read,
  output logic               mdren,
  output logic               mdrout,
  output logic               iren,
  output logic               yen,
  output logic               cout,
  output logic               hien,
  output logic               loen,
  output logic               gra,
  output logic               grb,
  output logic               grc,
  output logic               rin,
  output logic               rout,
  output logic [4:0]         alu_control,
  output logic               run,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q;
  logic               retire_d;
  cls_e               cls;
  logic [4:0]         op;
  logic               unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  op_classify u_cls (
    .opcode_i (op),
    .cls_o    (cls)
  );

  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        unique case (cls)
          C_NOP: begin
            state_d  = S_T0;
            retire_d = 1'b1;
          end
          C_HALT: begin
            state_d  = S_HALT;
            retire_d = 1'b1;
          end
          C_ILLEGAL:
            state_d = HALT_ON_ILLEGAL ? S_HALT : S_T0;
          default:
            state_d = S_T4;
        endcase
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (cls == C_MULDIV) begin
          state_d = S_T6;
        end else begin
          state_d  = S_T0;
          retire_d = 1'b1;
        end
      end
      S_T6: begin
        state_d  = S_T0;
        retire_d = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) begin
        cnt_q <= cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign instr_count = cnt_q;

  // Strobes depend only on the current state and the IR class.
  always_comb begin
    pout        = 1'b0;
    maren       = 1'b0;
    zloen       = 1'b0;
    zhien       = 1'b0;
    zloout      = 1'b0;
    zhiout      = 1'b0;
    pen         = 1'b0;
    read        = 1'b0;
    mdren       = 1'b0;
    mdrout      = 1'b0;
    iren        = 1'b0;
    yen         = 1'b0;
    cout        = 1'b0;
    hien        = 1'b0;
    loen        = 1'b0;
    gra         = 1'b0;
    grb         = 1'b0;
    grc         = 1'b0;
    rin         = 1'b0;
    rout        = 1'b0;
    alu_control = 5'b00000;
    illegal     = 1'b0;
    run         = (state_q != S_IDLE) &&
                  (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin
        pout        = 1'b1;
        maren       = 1'b1;
        zloen       = 1'b1;
        alu_control = ALU_INC;
      end
      S_T1: begin
        zloout = 1'b1;
        pen    = 1'b1;
        read   = 1'b1;
        mdren  = 1'b1;
      end
      S_T2: begin
        mdrout = 1'b1;
        iren   = 1'b1;
      end
      S_T3: begin
        unique case (cls)
          C_ALU3, C_IMM, C_MULDIV, C_UNARY: begin
            grb  = 1'b1;
            rout = 1'b1;
            yen  = 1'b1;
          end
          C_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        alu_control = op;
        zloen       = 1'b1;
        unique case (cls)
          C_ALU3: begin
            grc  = 1'b1;
            rout = 1'b1;
          end
          C_IMM: cout = 1'b1;
          C_MULDIV: begin
            grc   = 1'b1;
            rout  = 1'b1;
            zhien = 1'b1;
          end
          C_UNARY: begin
            grb  = 1'b1;
            rout = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        zloout = 1'b1;
        if (cls == C_MULDIV) begin
          loen = 1'b1;
        end else begin
          gra = 1'b1;
          rin = 1'b1;
        end
      end
      S_T6: begin
        zhiout = 1'b1;
        hien   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Queue-based reference model of per-cycle control
// words checked against control_sequencer.
module tb_control_sequencer;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          clr;
  logic [31:0]   ir;
  logic          pout, maren, zloen, zhien, zloout;
  logic          zhiout, pen, read, mdren, mdrout;
  logic          iren, yen, cout, hien, loen;
  logic          gra, grb, grc, rin, rout;
  logic [4:0]    alu_control;
  logic          run, illegal;
  logic [CW-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  control_sequencer #(
    .COUNT_W         (CW),
    .HALT_ON_ILLEGAL (1'b0)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .ir          (ir),
    .pout        (pout),
    .maren       (maren),
    .zloen       (zloen),
    .zhien       (zhien),
    .zloout      (zloout),
    .zhiout      (zhiout),
    .pen         (pen),
    .read        (read),
    .mdren       (mdren),
    .mdrout      (mdrout),
    .iren        (iren),
    .yen         (yen),
    .cout        (cout),
    .hien        (hien),
    .loen        (loen),
    .gra         (gra),
    .grb         (grb),
    .grc         (grc),
    .rin         (rin),
    .rout        (rout),
    .alu_control (alu_control),
    .run         (run),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [21:0] POUT   = 22'd1 << 0;
  localparam logic [21:0] MAREN  = 22'd1 << 1;
  localparam logic [21:0] ZLOEN  = 22'd1 << 2;
  localparam logic [21:0] ZHIEN  = 22'd1 << 3;
  localparam logic [21:0] ZLOOUT = 22'd1 << 4;
  localparam logic [21:0] ZHIOUT = 22'd1 << 5;
  localparam logic [21:0] PEN    = 22'd1 << 6;
  localparam logic [21:0] READ   = 22'd1 << 7;
  localparam logic [21:0] MDREN  = 22'd1 << 8;
  localparam logic [21:0] MDROUT = 22'd1 << 9;
  localparam logic [21:0] IREN   = 22'd1 << 10;
  localparam logic [21:0] YEN    = 22'd1 << 11;
  localparam logic [21:0] COUT   = 22'd1 << 12;
  localparam logic [21:0] HIEN   = 22'd1 << 13;
  localparam logic [21:0] LOEN   = 22'd1 << 14;
  localparam logic [21:0] GRA    = 22'd1 << 15;
  localparam logic [21:0] GRB    = 22'd1 << 16;
  localparam logic [21:0] GRC    = 22'd1 << 17;
  localparam logic [21:0] RIN    = 22'd1 << 18;
  localparam logic [21:0] ROUT   = 22'd1 << 19;
  localparam logic [21:0] RUN    = 22'd1 << 20;
  localparam logic [21:0] ILL    = 22'd1 << 21;

  typedef struct {
    logic [26:0] w;
    bit          ret;
    string       tag;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] mcnt = '0;

  function automatic logic [26:0] dutw();
    return {alu_control, illegal, run, rout, rin,
            grc, grb, gra, loen, hien, cout, yen,
            iren, mdrout, mdren, read, pen, zhiout,
            zloout, zhien, zloen, maren, pout};
  endfunction

  function automatic exp_t mk(
    input logic [21:0] m, input logic [4:0] a,
    input bit r, input string t);
    exp_t e;
    e.w   = {a, m};
    e.ret = r;
    e.tag = t;
    return e;
  endfunction

  // 0 alu3, 1 imm, 2 muldiv, 3 unary, 4 nop, 5 halt, 6 illegal
  function automatic int mclass(input int op);
    if (op >= 3 && op <= 11) return 0;
    if (op >= 12 && op <= 14) return 1;
    if (op == 15 || op == 16) return 2;
    if (op == 17 || op == 18) return 3;
    if (op == 26) return 4;
    if (op == 27) return 5;
    return 6;
  endfunction

  task automatic issue(input logic [31:0] v,
                       input int cut = 99);
    exp_t l[$];
    logic [4:0] op;
    int c;
    op = v[31:27];
    c  = mclass(int'(op));
    ir = v;
    l.push_back(mk(POUT|MAREN|ZLOEN|RUN,
                   5'h1f, 0, "T0"));
    l.push_back(mk(ZLOOUT|PEN|READ|MDREN|RUN,
                   5'h0, 0, "T1"));
    l.push_back(mk(MDROUT|IREN|RUN, 5'h0, 0, "T2"));
    if (c <= 3) begin
      l.push_back(mk(GRB|ROUT|YEN|RUN, 5'h0, 0, "T3"));
      if (c == 0)
        l.push_back(mk(GRC|ROUT|ZLOEN|RUN, op, 0, "T4"));
      else if (c == 1)
        l.push_back(mk(COUT|ZLOEN|RUN, op, 0, "T4"));
      else if (c == 2)
        l.push_back(mk(GRC|ROUT|ZLOEN|ZHIEN|RUN, op,
                       0, "T4"));
      else
        l.push_back(mk(GRB|ROUT|ZLOEN|RUN, op, 0, "T4"));
      if (c == 2) begin
        l.push_back(mk(ZLOOUT|LOEN|RUN, 5'h0, 0, "T5"));
        l.push_back(mk(ZHIOUT|HIEN|RUN, 5'h0, 1, "T6"));
      end else begin
        l.push_back(mk(ZLOOUT|GRA|RIN|RUN, 5'h0, 1, "T5"));
      end
    end else if (c == 4) begin
      l.push_back(mk(RUN, 5'h0, 1, "T3"));
    end else if (c == 5) begin
      l.push_back(mk(RUN, 5'h0, 1, "T3"));
      for (int i = 0; i < 10; i++)
        l.push_back(mk(22'h0, 5'h0, 0, "HALT"));
    end else begin
      l.push_back(mk(RUN|ILL, 5'h0, 0, "T3"));
    end
    for (int i = 0; i < l.size() && i < cut; i++)
      q.push_back(l[i]);
  endtask

  // Single compare process; the retire counter is modelled here too.
  initial begin
    exp_t e;
    bit   pend;
    forever begin
      @(negedge clk);
      pend = 0;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (dutw() !== e.w) begin
          failures++;
          $display("FAIL out_%s got=%h exp=%h",
                   e.tag, dutw(), e.w);
        end
        checks++;
        if (instr_count !== mcnt) begin
          failures++;
          $display("FAIL count_%s got=%0d exp=%0d",
                   e.tag, instr_count, mcnt);
        end
        pend = e.ret;
      end
      @(posedge clk);
      if (clr) mcnt = '0;
      else if (pend) mcnt = mcnt + 1'b1;
    end
  end

  task automatic lit(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      if (q.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0",
               q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic drain_neg();
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      #2;
      if (q.size() == 0) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drainn_timeout got=%0d exp=0",
               q.size());
      q.delete();
    end
  endtask

  initial begin
    clr = 1'b1;
    ir  = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    #2;
    lit("idle_word", 32'(dutw()), 32'h0);
    lit("idle_cnt", 32'(instr_count), 32'd0);
    issue(32'h28918000);
    @(negedge clk);
    #2;
    lit("t0_word", 32'(dutw()),
        32'h07c00000 | 32'(POUT|MAREN|ZLOEN|RUN));
    drain();
    issue(32'h80118000);
    @(negedge clk);
    #2;
    lit("cnt_after_and", 32'(instr_count), 32'd1);
    drain();
    issue(32'h60900005);
    @(negedge clk);
    #2;
    lit("cnt_after_mul", 32'(instr_count), 32'd2);
    drain();
    issue(32'hF0000000);
    drain();
    issue(32'h20918000);
    drain();
    issue(32'h38918000);
    drain();
    issue(32'h78918000);
    drain();
    issue(32'h88900000);
    drain();
    issue(32'h90900000);
    drain();
    issue(32'h68900007);
    drain();
    issue(32'hD0000000);
    drain();
    issue(32'hD8000000);
    drain();
    @(negedge clk);
    #2;
    lit("halt_run", 32'(run), 32'd0);
    lit("halt_cnt", 32'(instr_count), 32'd3);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    #2;
    lit("clr_idle_word", 32'(dutw()), 32'h0);
    issue(32'h18918000, 5);
    drain_neg();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    #2;
    lit("midclr_zloen", 32'(zloen), 32'd0);
    lit("midclr_run", 32'(run), 32'd0);
    lit("midclr_cnt", 32'(instr_count), 32'd0);
    issue(32'hD0000000);
    drain();
    @(negedge clk);
    #2;
    lit("cnt_after_nop", 32'(instr_count), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
